// File: rtl/sm_in_debounce.sv
// rtl/sm_in_debounce.sv - two-channel 2-flop synchroniser and debouncer ahead of the control FSM
// Optional rejected-glitch counter enabled by defining SM_DB_GLITCH_CNT_EN.
module sm_in_debounce #(
  parameter int DB_CYCLES = 4,
  parameter int CW        = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       raw1,
  input  logic       raw2,
  output logic       i1,
  output logic       i2,
  output logic       chg,
  output logic       pending
`ifdef SM_DB_GLITCH_CNT_EN
  ,
  input  logic       glitch_clr,
  output logic [7:0] glitch_cnt
`endif
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_t;

  logic [1:0]         r_sa;
  logic [1:0]         r_sb;
  logic [1:0]         r_out;
  logic [1:0][CW-1:0] r_cnt;
  db_state_t          r_state [2];
  logic               r_chg;
  logic               r_pending;

  logic [1:0]         w_out_nxt;
  logic [1:0][CW-1:0] w_cnt_nxt;
  db_state_t          w_state_nxt [2];

  // Index 0 is channel 1, index 1 is channel 2; channels never interact.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_out_nxt[c]   = r_out[c];
      w_cnt_nxt[c]   = r_cnt[c];
      w_state_nxt[c] = r_state[c];
      if (r_state[c] == ST_STABLE) begin
        if (r_sb[c] != r_out[c]) begin
          w_state_nxt[c] = ST_PENDING;
          w_cnt_nxt[c]   = CW'(1);
        end else begin
          w_cnt_nxt[c]   = '0;
        end
      end else begin
        if (r_sb[c] == r_out[c]) begin
          w_state_nxt[c] = ST_STABLE;
          w_cnt_nxt[c]   = '0;
        end else if (r_cnt[c] == CW'(DB_CYCLES - 1)) begin
          w_out_nxt[c]   = r_sb[c];
          w_state_nxt[c] = ST_STABLE;
          w_cnt_nxt[c]   = '0;
        end else begin
          w_cnt_nxt[c]   = r_cnt[c] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_sa      <= '0;
      r_sb      <= '0;
      r_out     <= '0;
      r_cnt     <= '0;
      r_chg     <= 1'b0;
      r_pending <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= ST_STABLE;
      end
    end else begin
      r_sa      <= {raw2, raw1};
      r_sb      <= r_sa;
      r_out     <= w_out_nxt;
      r_cnt     <= w_cnt_nxt;
      r_chg     <= |(w_out_nxt ^ r_out);
      r_pending <= (w_state_nxt[0] == ST_PENDING) || (w_state_nxt[1] == ST_PENDING);
      for (int c = 0; c < 2; c++) begin
        r_state[c] <= w_state_nxt[c];
      end
    end
  end

  assign i1      = r_out[0];
  assign i2      = r_out[1];
  assign chg     = r_chg;
  assign pending = r_pending;

`ifdef SM_DB_GLITCH_CNT_EN
  logic [1:0] w_rej;
  logic [8:0] w_gsum;
  logic [7:0] r_gcnt;

  // A glitch is rejected when a PENDING channel sees its input fall back to the held level.
  assign w_rej[0] = (r_state[0] == ST_PENDING) && (r_sb[0] == r_out[0]);
  assign w_rej[1] = (r_state[1] == ST_PENDING) && (r_sb[1] == r_out[1]);
  assign w_gsum   = {1'b0, r_gcnt} + 9'(w_rej[0]) + 9'(w_rej[1]);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_gcnt <= '0;
    end else if (glitch_clr) begin
      r_gcnt <= '0;
    end else if (w_gsum > 9'd255) begin
      r_gcnt <= 8'd255;
    end else begin
      r_gcnt <= w_gsum[7:0];
    end
  end

  assign glitch_cnt = r_gcnt;
`endif

endmodule

// File: tb/tb_sm_in_debounce.sv
// tb/tb_sm_in_debounce.sv - scoreboard bench for sm_in_debounce (DB_CYCLES=4)
module tb_sm_in_debounce;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic nrst;
  logic raw1;
  logic raw2;
  logic i1;
  logic i2;
  logic chg;
  logic pending;
`ifdef SM_DB_GLITCH_CNT_EN
  logic       glitch_clr;
  logic [7:0] glitch_cnt;
  int         exp_gl = 0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic seen;

  typedef struct {
    int   edge_n;
    logic e1;
    logic e2;
  } exp_t;
  exp_t sb_q[$];

  sm_in_debounce #(.DB_CYCLES(DB), .CW(3)) dut (
    .clk(clk),
    .nrst(nrst),
    .raw1(raw1),
    .raw2(raw2),
    .i1(i1),
    .i2(i2),
    .chg(chg),
    .pending(pending)
`ifdef SM_DB_GLITCH_CNT_EN
    ,
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge: the next posedge samples the new raw level.
  task automatic expect_chg(input logic e1, input logic e2);
    exp_t e;
    e.edge_n = cyc + 1 + DB + 1;
    e.e1     = e1;
    e.e2     = e2;
    sb_q.push_back(e);
  endtask

  task automatic add_gl(input int n);
`ifdef SM_DB_GLITCH_CNT_EN
    exp_gl = (exp_gl + n > 255) ? 255 : exp_gl + n;
`endif
  endtask

  task automatic check_gl(input string tag);
`ifdef SM_DB_GLITCH_CNT_EN
    check_eq(tag, 32'(glitch_cnt), 32'(exp_gl));
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic c1, input logic c2, input int len, output logic pseen);
    pseen = 1'b0;
    if (c1) raw1 = ~raw1;
    if (c2) raw2 = ~raw2;
    repeat (len) begin
      @(negedge clk);
      pseen |= pending;
    end
    if (c1) raw1 = ~raw1;
    if (c2) raw2 = ~raw2;
    repeat (DB + 4) begin
      @(negedge clk);
      pseen |= pending;
    end
  endtask

  always @(negedge clk) begin
    if (nrst && chg) begin
      if (sb_q.size() == 0) begin
        check_eq("chg_unexpected", 32'(chg), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("chg_edge", 32'(cyc), 32'(e.edge_n));
        check_eq("chg_i1", 32'(i1), 32'(e.e1));
        check_eq("chg_i2", 32'(i2), 32'(e.e2));
      end
    end
  end

  initial begin
    nrst = 1'b0;
    raw1 = 1'b1;
    raw2 = 1'b1;
`ifdef SM_DB_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    tick(3);
    check_eq("rst_i1", 32'(i1), 32'd0);
    check_eq("rst_i2", 32'(i2), 32'd0);
    check_eq("rst_chg", 32'(chg), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_gl("rst_glitch_cnt");

    nrst = 1'b1;
    expect_chg(1'b1, 1'b1);
    tick(DB + 6);

    raw1 = 1'b0;
    expect_chg(1'b0, 1'b1);
    for (int k = 0; k <= DB + 2; k++) begin
      @(negedge clk);
      check_eq($sformatf("step_pend_e%0d", k), 32'(pending), 32'((k >= 2) && (k <= DB)));
    end
    tick(3);

    pulse(1'b1, 1'b0, 2, seen);
    add_gl(1);
    check_eq("glitch_pend_seen", 32'(seen), 32'd1);
    check_eq("glitch_i1", 32'(i1), 32'd0);
    check_gl("glitch_cnt_1");

    raw1 = 1'b1;
    expect_chg(1'b1, 1'b1);
    tick(DB + 5);

    pulse(1'b0, 1'b1, DB - 1, seen);
    add_gl(1);
    check_eq("short_i2", 32'(i2), 32'd1);
    check_gl("glitch_cnt_short");

    raw2 = 1'b0;
    expect_chg(1'b1, 1'b0);
    tick(DB);
    raw2 = 1'b1;
    expect_chg(1'b1, 1'b1);
    tick(DB + 5);

    raw1 = 1'b0;
    raw2 = 1'b0;
    expect_chg(1'b0, 1'b0);
    tick(DB + 5);
    check_eq("simul_i1", 32'(i1), 32'd0);
    check_eq("simul_i2", 32'(i2), 32'd0);

    pulse(1'b1, 1'b1, 2, seen);
    add_gl(2);
    check_gl("glitch_cnt_dual");

    raw1 = 1'b1;
    expect_chg(1'b1, 1'b0);
    tick(3);
    check_eq("midrst_pend_before", 32'(pending), 32'd1);
    nrst = 1'b0;
    #1;
    check_eq("midrst_i1", 32'(i1), 32'd0);
    check_eq("midrst_pending", 32'(pending), 32'd0);
    check_eq("midrst_chg", 32'(chg), 32'd0);
    sb_q.delete();
`ifdef SM_DB_GLITCH_CNT_EN
    exp_gl = 0;
`endif
    check_gl("midrst_glitch_cnt");
    tick(2);
    nrst = 1'b1;
    expect_chg(1'b1, 1'b0);
    tick(DB + 5);
    check_eq("midrst_i1_after", 32'(i1), 32'd1);

`ifdef SM_DB_GLITCH_CNT_EN
    for (int n = 0; n < 150; n++) begin
      pulse(1'b1, 1'b1, 2, seen);
      add_gl(2);
    end
    check_gl("glitch_cnt_sat");
    glitch_clr = 1'b1;
    pulse(1'b1, 1'b0, 2, seen);
    glitch_clr = 1'b0;
    exp_gl = 0;
    check_gl("glitch_clr_prio");
`endif

    tick(2);
    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
